cpu_run_ctrl: RTL

- Hardware run controller for the CPU core.
- Generates a stretched core reset and a clock-enable, and counts executed cycles.
- Stops the core on a cycle limit or on PC-stall (halt-loop) detection.
- Supports free-run and single-step modes.
- Sits between board/bench Clock/Reset and the CPU, making the cycle budget and halt behaviour synthesizable and parametrised.

---
 rtl/cpu_run_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_run_ctrl : core reset stretcher, clock-enable generator, cycle budget and
//                PC-stall (halt-loop) stop, with free-run and single-step modes
// Revision     : 1.0
// ----------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int PC_N        = 8,
  parameter int CNT_N       = 16,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 100,
  parameter int HALT_CYCLES = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [PC_N-1:0]  pc_pc,
  input  logic             mode,
  input  logic             step,
  input  logic             restart,
  output logic             cpu_rst_n,
  output logic             cpu_en,
  output logic [CNT_N-1:0] cycle_count,
  output logic             done,
  output logic             halted,
  output logic             timeout
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SC_W = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_TMO  = 2'd3
  } state_t;

  state_t            state_q,       state_d;
  logic [RC_W-1:0]   rst_cnt_q,     rst_cnt_d;
  logic              cpu_rst_n_q,   cpu_rst_n_d;
  logic              cpu_en_q,      cpu_en_d;
  logic [CNT_N-1:0]  cycle_count_q, cycle_count_d;
  logic              done_q,        done_d;
  logic              halted_q,      halted_d;
  logic              timeout_q,     timeout_d;
  logic [SC_W-1:0]   stall_cnt_q,   stall_cnt_d;
  logic [PC_N-1:0]   last_pc_q,     last_pc_d;
  logic              step_q,        step_d;

  logic en_req;
  logic pc_same;
  logic halt_hit;
  logic tmo_hit;

  always_comb begin
    // In step mode only a fresh 0->1 on step grants the next enabled cycle
    en_req   = mode ? (step & ~step_q) : 1'b1;
    pc_same  = (pc_pc == last_pc_q);
    halt_hit = cpu_en_q && pc_same && (stall_cnt_q == SC_W'(HALT_CYCLES - 1));
    tmo_hit  = cpu_en_q && (cycle_count_q == CNT_N'(MAX_CYCLES - 1));

    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cpu_rst_n_d   = cpu_rst_n_q;
    cpu_en_d      = cpu_en_q;
    cycle_count_d = cycle_count_q;
    done_d        = done_q;
    halted_d      = halted_q;
    timeout_d     = timeout_q;
    stall_cnt_d   = stall_cnt_q;
    last_pc_d     = last_pc_q;
    step_d        = step;

    if (restart) begin
      state_d       = S_RST;
      rst_cnt_d     = '0;
      cpu_rst_n_d   = 1'b0;
      cpu_en_d      = 1'b0;
      cycle_count_d = '0;
      stall_cnt_d   = '0;
      done_d        = 1'b0;
      halted_d      = 1'b0;
      timeout_d     = 1'b0;
    end else begin
      case (state_q)
        S_RST: begin
          rst_cnt_d     = rst_cnt_q + RC_W'(1);
          cpu_rst_n_d   = 1'b0;
          cpu_en_d      = 1'b0;
          cycle_count_d = '0;
          stall_cnt_d   = '0;
          done_d        = 1'b0;
          halted_d      = 1'b0;
          timeout_d     = 1'b0;
          if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
            state_d     = S_RUN;
            rst_cnt_d   = '0;
            cpu_rst_n_d = 1'b1;
            cpu_en_d    = en_req;
          end
        end
        S_RUN: begin
          cpu_en_d = en_req;
          if (cpu_en_q) begin
            cycle_count_d = cycle_count_q + CNT_N'(1);
            stall_cnt_d   = pc_same ? (stall_cnt_q + SC_W'(1)) : '0;
            last_pc_d     = pc_pc;
          end
          // Halt takes priority when both stop conditions land on one cycle
          if (halt_hit) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            done_d   = 1'b1;
            cpu_en_d = 1'b0;
          end else if (tmo_hit) begin
            state_d   = S_TMO;
            timeout_d = 1'b1;
            done_d    = 1'b1;
            cpu_en_d  = 1'b0;
          end
        end
        default: begin
          cpu_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_RST;
      rst_cnt_q     <= '0;
      cpu_rst_n_q   <= 1'b0;
      cpu_en_q      <= 1'b0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
      stall_cnt_q   <= '0;
      last_pc_q     <= '0;
      step_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      cpu_en_q      <= cpu_en_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      halted_q      <= halted_d;
      timeout_q     <= timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      last_pc_q     <= last_pc_d;
      step_q        <= step_d;
    end
  end

  assign cpu_rst_n   = cpu_rst_n_q;
  assign cpu_en      = cpu_en_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;

endmodule
`default_nettype wire
